// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } tx_state_t;

  localparam int TX_STATE_COUNT = 7;
  localparam int PARITY_MAX_W   = 64;

  // Zero-extension does not change the XOR, so one wide helper serves every DATA_WIDTH.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen between the FIFO (slave) and the transmitter (master).
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;

  modport master (input empty, input rd_data, output rd_en);
  modport slave  (output empty, output rd_data, input rd_en);
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Per-bit cycle counter; o_tick marks the last cycle of a serial bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign o_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_tick) cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO word per frame and serialises it: start, data LSB first,
// optional even parity, stop bit(s).
//   state  | meaning
//   IDLE   | line high, waiting for enable and a non-empty FIFO
//   POP    | one-cycle FIFO read strobe
//   LOAD   | FIFO data valid; capture into shift register and parity
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | even-parity bit
//   STOP   | stop bit(s) (high)
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  fifo_uart_tx_if.master  fifo,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state, next_state;
  logic                  state_change;
  logic                  baud_tick;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parity_q;
  logic                  done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (i_enable && !fifo.empty) next_state = S_POP;
      S_POP:    next_state = S_LOAD;
      S_LOAD:   next_state = S_START;
      S_START:  if (baud_tick) next_state = S_DATA;
      S_DATA:   if (baud_tick && (bit_cnt == BIT_W'(DATA_WIDTH - 1)))
                  next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) next_state = S_STOP;
      S_STOP:   if (baud_tick && (bit_cnt == BIT_W'(STOP_BITS - 1))) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Every state entry restarts both the baud and bit counters.
  assign state_change = (next_state != state);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state_change),
    .o_tick  (baud_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_STOP) && (next_state == S_IDLE);
      if (state_change)
        bit_cnt <= '0;
      else if (baud_tick && ((state == S_DATA) || (state == S_STOP)))
        bit_cnt <= bit_cnt + BIT_W'(1);
      if (state == S_LOAD) begin
        shift_q  <= fifo.rd_data;
        parity_q <= even_parity(PARITY_MAX_W'(fifo.rd_data));
      end else if ((state == S_DATA) && baud_tick) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  always_comb begin
    o_tx       = 1'b1;
    o_busy     = 1'b1;
    fifo.rd_en = 1'b0;
    o_done     = done_q;
    unique case (state)
      S_IDLE:   o_busy     = 1'b0;
      S_POP:    fifo.rd_en = 1'b1;
      S_LOAD:   o_tx       = 1'b1;
      S_START:  o_tx       = 1'b0;
      S_DATA:   o_tx       = shift_q[0];
      S_PARITY: o_tx       = parity_q;
      S_STOP:   o_tx       = 1'b1;
      default:  o_busy     = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: behavioural FIFOs feed two transmitters (no parity / even parity, 4 clocks per bit).
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b1;
  logic en1 = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-deep FIFO model for the no-parity transmitter
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
  logic       tx0, busy0, done0;
  logic       wr0_en = 1'b0;
  logic [7:0] wr0_data = 8'h00;
  logic [7:0] mem0 [0:15];
  logic [3:0] wptr0 = 4'd0, rptr0 = 4'd0;
  logic [4:0] cnt0 = 5'd0;
  logic       full0;

  assign if0.empty = (cnt0 == 5'd0);
  assign full0     = (cnt0 == 5'd16);

  always @(posedge clk) begin
    if (wr0_en && !full0) begin
      mem0[wptr0] <= wr0_data;
      wptr0 <= wptr0 + 4'd1;
    end
    if (if0.rd_en && !if0.empty) begin
      if0.rd_data <= mem0[rptr0];
      rptr0 <= rptr0 + 4'd1;
    end
    cnt0 <= cnt0 + 5'(wr0_en && !full0) - 5'(if0.rd_en && !if0.empty);
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en0), .fifo(if0),
    .o_tx(tx0), .o_busy(busy0), .o_done(done0));

  // One-word source for the parity transmitter
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();
  logic       tx1, busy1, done1;
  logic [7:0] p_byte = 8'h00;
  int         p_push = 0;
  int         p_pop = 0;

  assign if1.empty = (p_push == p_pop);

  always @(posedge clk) begin
    if (if1.rd_en && !if1.empty) begin
      if1.rd_data <= p_byte;
      p_pop <= p_pop + 1;
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en1), .fifo(if1),
    .o_tx(tx1), .o_busy(busy1), .o_done(done1));

  logic [7:0] f_data;
  logic       f_par;
  int         f_start, f_pop_cyc, f_pops, f_dones;
  logic       f_shape, f_timeout;

  function automatic logic tx_of(input int d);
    return (d == 0) ? tx0 : tx1;
  endfunction
  function automatic logic rd_of(input int d);
    return (d == 0) ? if0.rd_en : if1.rd_en;
  endfunction
  function automatic logic done_of(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] b);
    wr0_en = 1'b1;
    wr0_data = b;
    @(negedge clk);
    wr0_en = 1'b0;
  endtask

  // Waits for a start bit, samples every cycle of the frame plus the following cycle.
  task automatic watch(input int d, input int nslots, input int drop_at);
    logic samp [0:43];
    int   guard = 0;
    f_pops = 0; f_dones = 0; f_shape = 1'b1; f_timeout = 1'b0;
    f_data = 8'h00; f_par = 1'b0; f_pop_cyc = -100; f_start = -100;
    @(negedge clk);
    while (tx_of(d) !== 1'b0 && guard < 300) begin
      if (rd_of(d)) begin f_pops++; f_pop_cyc = cyc; end
      if (done_of(d)) f_dones++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) begin
      f_timeout = 1'b1;
      return;
    end
    f_start = cyc;
    for (int j = 0; j < nslots * 4; j++) begin
      if (j > 0) @(negedge clk);
      if (j == drop_at) en0 = 1'b0;
      samp[j] = tx_of(d);
      if (rd_of(d)) f_pops++;
      if (done_of(d)) f_dones++;
    end
    @(negedge clk);
    if (rd_of(d)) f_pops++;
    if (done_of(d)) f_dones++;
    for (int k = 0; k < nslots; k++)
      for (int m = 1; m < 4; m++)
        if (samp[4*k+m] !== samp[4*k]) f_shape = 1'b0;
    if (samp[0] !== 1'b0 || samp[4*(nslots-1)] !== 1'b1) f_shape = 1'b0;
    for (int i = 0; i < 8; i++) f_data[i] = samp[4*(1+i)];
    if (nslots == 11) f_par = samp[36];
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp);
    chk({tag, "_timeout"}, 32'(f_timeout), 32'd0);
    chk({tag, "_data"},    32'(f_data),    32'(exp));
    chk({tag, "_shape"},   32'(f_shape),   32'd1);
    chk({tag, "_pops"},    32'(f_pops),    32'd1);
    chk({tag, "_dones"},   32'(f_dones),   32'd1);
  endtask

  initial begin
    int prev;
    int viol;
    int guard;

    // 1: reset with empty FIFO, then stay idle
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", 32'({tx0, busy0, if0.rd_en, done0}), 32'h8);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_rst", 32'({tx0, busy0, if0.rd_en, done0}), 32'h8);
    end

    // 2: single byte 0xA5
    push0(8'hA5);
    watch(0, 10, -1);
    check_frame("a5", 8'hA5);
    chk("a5_latency", 32'(f_start - f_pop_cyc), 32'd2);
    chk("a5_empty_after", 32'(if0.empty), 32'd1);
    chk("a5_busy_after", 32'(busy0), 32'd0);

    // 3: three queued bytes back to back, then a full FIFO
    en0 = 1'b0;
    push0(8'h01); push0(8'h02); push0(8'h03);
    en0 = 1'b1;
    prev = 0;
    for (int i = 1; i <= 3; i++) begin
      watch(0, 10, -1);
      check_frame("seq3", 8'(i));
      if (i > 1) chk("seq3_spacing", 32'(f_start - prev), 32'd43);
      prev = f_start;
    end
    en0 = 1'b0;
    for (int i = 0; i < 16; i++) push0(8'(i));
    chk("fill_full", 32'(full0), 32'd1);
    en0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      watch(0, 10, -1);
      chk("fill_data", 32'(f_data), 32'(i));
      if (i == 0) chk("fill_full_cleared", 32'(full0), 32'd0);
      if (i > 0) chk("fill_spacing", 32'(f_start - prev), 32'd43);
      prev = f_start;
    end
    chk("fill_empty_after", 32'(if0.empty), 32'd1);

    // 4: even parity, 44-cycle frames
    p_byte = 8'h07; p_push = p_push + 1;
    watch(1, 11, -1);
    check_frame("par07", 8'h07);
    chk("par07_bit", 32'(f_par), 32'd1);
    p_byte = 8'h03; p_push = p_push + 1;
    watch(1, 11, -1);
    check_frame("par03", 8'h03);
    chk("par03_bit", 32'(f_par), 32'd0);

    // 5: enable dropped during DATA of the first of two frames
    en0 = 1'b0;
    push0(8'h5A); push0(8'hC3);
    en0 = 1'b1;
    watch(0, 10, 8);
    check_frame("drop_first", 8'h5A);
    chk("drop_busy", 32'(busy0), 32'd0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.rd_en !== 1'b0 || busy0 !== 1'b0) viol++;
    end
    chk("drop_quiet", 32'(viol), 32'd0);
    en0 = 1'b1;
    watch(0, 10, -1);
    check_frame("drop_second", 8'hC3);

    // 6: one-cycle reset in the middle of DATA
    en0 = 1'b0;
    push0(8'h96); push0(8'h3C);
    en0 = 1'b1;
    guard = 0;
    @(negedge clk);
    while (tx0 !== 1'b0 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    chk("rst6_start_seen", 32'(guard < 300), 32'd1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst6_line", 32'({tx0, busy0, if0.rd_en}), 32'h4);
    chk("rst6_fifo_left", 32'(cnt0), 32'd1);
    rst = 1'b0;
    watch(0, 10, -1);
    check_frame("rst6_next", 8'h3C);
    chk("rst6_empty_after", 32'(if0.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
